// File: rtl/sel_arb_pkg.sv
// sel_arb_pkg: shared definitions for the A/B selector arbiter.
//   state_e     arbiter FSM encoding (IDLE, OWN_A, OWN_B, TURN)
//   SEL_A/SEL_B selector control values (1 selects A, 0 selects B)
package sel_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWN_A = 2'b01,
    ST_OWN_B = 2'b10,
    ST_TURN  = 2'b11
  } state_e;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/sel_arb_mux.sv
// sel_arb_mux: registered WIDTH-bit 2:1 selector with a valid flop.
// Ports:
//   CLK, RST_N   clock / async active-low reset
//   gnt_i        a grant is active this cycle (capture enable)
//   sel_i        1 = take a_i, 0 = take b_i
//   a_i, b_i     candidate data
//   q_o          captured data, holds while no grant is active
//   q_valid_o    q_o was captured under a grant on the last edge
module sel_arb_mux
  import sel_arb_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             gnt_i,
  input  logic             sel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] q_o,
  output logic             q_valid_o
);

  logic [WIDTH-1:0] q_q;
  logic             vld_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= gnt_i;
      if (gnt_i) q_q <= (sel_i == SEL_A) ? a_i : b_i;
    end
  end

  assign q_o       = q_q;
  assign q_valid_o = vld_q;

endmodule

// File: rtl/sel_arbiter.sv
// sel_arbiter: shares one 2:1 data selector between requesters A and B.
// Round-robin on contention (A wins the first tie after reset), with a
// one-cycle TURN gap whenever ownership passes directly to the other side.
// Optional feature macro: SEL_ARB_TIMEOUT_EN -- revokes an owner after
// MAX_HOLD owned cycles when the other side is waiting.
// Ports:
//   CLK, RST_N       clock / async active-low reset
//   REQ_A, REQ_B     requests
//   A, B             requester data
//   GNT_A, GNT_B     registered grants (mutually exclusive)
//   SEL              registered selector control (1=A, 0=B)
//   Q, Q_VALID       registered selected data and its valid flag
module sel_arbiter
  import sel_arb_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ_A,
  input  logic             REQ_B,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             GNT_A,
  output logic             GNT_B,
  output logic             SEL,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID
);

  if (WIDTH < 1 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("sel_arbiter: WIDTH and MAX_HOLD must be >= 1");
  end

  state_e state_q, state_d;
  logic   sel_q, sel_d;
  logic   last_a_q, last_a_d;   // 1 = A was the most recent owner
  logic   owning;
  logic   enter_own;
  logic   pick_a;
  logic   hold_exp;             // owner has used up its hold budget

  assign owning = (state_q == ST_OWN_A) || (state_q == ST_OWN_B);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_a_d  = last_a_q;
    enter_own = 1'b0;
    // Tie goes to whoever was not served last; otherwise the lone requester.
    pick_a    = (REQ_A && REQ_B) ? !last_a_q : REQ_A;
    unique case (state_q)
      // TURN is a single dead cycle that then arbitrates exactly like IDLE.
      ST_IDLE, ST_TURN: begin
        if (REQ_A || REQ_B) state_d = pick_a ? ST_OWN_A : ST_OWN_B;
        else                state_d = ST_IDLE;
      end
      ST_OWN_A: if (!REQ_A || (hold_exp && REQ_B)) state_d = REQ_B ? ST_TURN : ST_IDLE;
      ST_OWN_B: if (!REQ_B || (hold_exp && REQ_A)) state_d = REQ_A ? ST_TURN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // SEL and LAST move only when a fresh grant is taken.
    if (!owning && (state_d == ST_OWN_A || state_d == ST_OWN_B)) begin
      enter_own = 1'b1;
      sel_d     = (state_d == ST_OWN_A) ? SEL_A : SEL_B;
      last_a_d  = (state_d == ST_OWN_A);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      sel_q    <= SEL_B;
      last_a_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_a_q <= last_a_d;
    end
  end

`ifdef SEL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] hold_q, hold_d;

  assign hold_exp = (hold_q == CW'(MAX_HOLD - 1));

  // Saturates at MAX_HOLD-1 so an uncontended long grant is revoked as soon
  // as the other side shows up, and never wraps.
  always_comb begin
    hold_d = hold_q;
    if (enter_own)                hold_d = '0;
    else if (owning && !hold_exp) hold_d = hold_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  assign hold_exp = 1'b0;
`endif

  assign GNT_A = (state_q == ST_OWN_A);
  assign GNT_B = (state_q == ST_OWN_B);
  assign SEL   = sel_q;

  sel_arb_mux #(.WIDTH(WIDTH)) u_mux (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .gnt_i     (owning),
    .sel_i     (sel_q),
    .a_i       (A),
    .b_i       (B),
    .q_o       (Q),
    .q_valid_o (Q_VALID)
  );

endmodule
